l2_instruction_responder: RTL and testbench
===========================================

// Module: l2_instruction_responder
// PURPOSE
// L2-side responder for the L1 instruction-cache refill interface. Accepts a block-miss word
// address from the L1 I-cache (ADDRESS_TO_L2_*), reads the block from the backing memory port
// one bus-width beat at a time, and returns the beats critical-beat-first (DATA_FROM_L2_*).
// Sits between the L1 I-cache and the L2/memory subsystem; one refill in flight at a time.
// PARAMETERS
// ADDRESS_WIDTH   32   byte-address width; L1 and memory addresses are word addresses (ADDRESS_WIDTH-2 bits)
// WORD_PER_BLOCK  16   32-bit words per cache block
// L2_BUS_WIDTH    WORD_PER_BLOCK*8 (=128), localparam; refill beat width in bits
// BEATS           WORD_PER_BLOCK*32/L2_BUS_WIDTH (=4), localparam; beats per block (power of 2, >=2)
// WPB_BEAT        L2_BUS_WIDTH/32 (=4), localparam; words per beat
// PORTS
// CLK                      in   1    clock, all state on rising edge
// RST_N                    in   1    asynchronous active-low reset
// ADDRESS_TO_L2_VALID_INS  in   1    L1 miss request valid
// ADDRESS_TO_L2_READY_INS  out  1    responder can accept request
// ADDRESS_TO_L2_INS        in   AW-2 missed word address (any word within the block)
// DATA_FROM_L2_VALID_INS   out  1    refill beat valid
// DATA_FROM_L2_READY_INS   in   1    L1 accepts beat
// DATA_FROM_L2_INS         out  L2_BUS_WIDTH  refill beat data, word 0 of beat in bits [31:0]
// MEM_REQ_VALID            out  1    backing-memory beat read request
// MEM_REQ_READY            in   1    memory accepts request
// MEM_ADDR                 out  AW-2 word address of beat (aligned to WPB_BEAT words)
// MEM_RDATA_VALID          in   1    memory read data valid (one pulse per accepted request)
// MEM_RDATA                in   L2_BUS_WIDTH  memory read data
// BUSY                     out  1    refill in progress (state != IDLE)
// BEHAVIOUR
// - Reset (RST_N=0, async): state IDLE, ADDRESS_TO_L2_READY_INS=1 after release (0 while RST_N=0),
//   DATA_FROM_L2_VALID_INS=0, DATA_FROM_L2_INS=0, MEM_REQ_VALID=0, MEM_ADDR=0, BUSY=0, beat count=0.
//   Reset mid-refill abandons it; no beats of the abandoned block are presented afterwards.
// - Handshakes: transfer on VALID&READY at rising edge. Output VALID, once high, holds with stable
//   data until READY; MEM_REQ_VALID likewise holds with stable MEM_ADDR until MEM_REQ_READY.
// - FSM: IDLE -> REQ -> WAIT -> SEND -> (REQ | IDLE).
//   IDLE: READY=1; on accept latch block base addr[AW-3:log2(WORD_PER_BLOCK)], start beat
//         b0 = addr[log2(WORD_PER_BLOCK)-1:log2(WPB_BEAT)], count=0 -> REQ.
//   REQ:  MEM_REQ_VALID=1, MEM_ADDR={base, beat, log2(WPB_BEAT) zeros}; on MEM_REQ_READY -> WAIT.
//   WAIT: on MEM_RDATA_VALID register MEM_RDATA into DATA_FROM_L2_INS -> SEND.
//   SEND: DATA_FROM_L2_VALID_INS=1; on DATA_FROM_L2_READY_INS: count+1, beat=(beat+1) mod BEATS;
//         if count was BEATS-1 -> IDLE else -> REQ.
// - Beat order wraps: b0, b0+1, ..., BEATS-1, 0, ..., b0-1. Exactly BEATS beats per request.
// - ADDRESS_TO_L2_READY_INS=1 only in IDLE; requests while busy are stalled, not dropped.
// - Latency: accept @T -> MEM_REQ_VALID @T+1; memory data @M -> DATA_FROM_L2_VALID_INS @M+1;
//   beat accepted @S -> next MEM_REQ_VALID @S+1. Back-to-back refills: new request may be
//   accepted the cycle after the last beat handshake (IDLE reached).
// - MEM_RDATA_VALID outside WAIT is ignored (no state change, no data capture).
// - Word addresses: MEM_ADDR upper bits never change within a refill (no carry out of block).
// TESTING
// - Reset: hold RST_N=0 mid-SEND -> all outputs at reset values same cycle; after release READY=1, no stray beat.
// - Aligned miss addr 0x0000_0100 (b0=0), memory latency 1, L1 ready=1 -> MEM_ADDR 0x100,0x104,0x108,0x10C in order, 4 beats.
// - Critical-first: addr 0x0000_010B (b0=2) -> MEM_ADDR 0x108,0x10C,0x100,0x104; DATA matches memory model per beat.
// - Backpressure: L1 READY low 5 cycles on beat 1, MEM_REQ_READY low 3 cycles -> VALID/data and MEM_ADDR held stable, no loss.
// - Busy stall: second request asserted during refill -> READY=0 until 1 cycle after last beat, then accepted and served.
// - Spurious MEM_RDATA_VALID in IDLE/REQ -> ignored; beat count and output data unchanged.

Source files
------------

// File: rtl/l2_instruction_responder.sv
// -----------------------------------------------------------------------------
// l2_instruction_responder
//
// L2-side responder for L1 instruction-cache refills. Takes one missed word
// address from the L1 I-cache, reads the enclosing block from the backing
// memory one bus-width beat at a time, and returns the beats critical-beat
// first, wrapping around the block. Only one refill is in flight at a time.
//
// Ports
//   CLK, RST_N                 clock (rising edge) / asynchronous active-low reset
//   ADDRESS_TO_L2_VALID_INS    in   L1 miss request valid
//   ADDRESS_TO_L2_READY_INS    out  high only while idle
//   ADDRESS_TO_L2_INS          in   missed word address (any word in the block)
//   DATA_FROM_L2_VALID_INS     out  refill beat valid
//   DATA_FROM_L2_READY_INS     in   L1 accepts beat
//   DATA_FROM_L2_INS           out  refill beat, word 0 of the beat in [31:0]
//   MEM_REQ_VALID              out  backing-memory beat read request
//   MEM_REQ_READY              in   memory accepts request
//   MEM_ADDR                   out  beat-aligned word address
//   MEM_RDATA_VALID            in   read data valid, one pulse per accepted request
//   MEM_RDATA                  in   read data
//   BUSY                       out  refill in progress
// -----------------------------------------------------------------------------
module l2_instruction_responder #(
    parameter  int ADDRESS_WIDTH  = 32,
    parameter  int WORD_PER_BLOCK = 16,
    localparam int L2_BUS_WIDTH   = WORD_PER_BLOCK * 8
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     ADDRESS_TO_L2_VALID_INS,
    output logic                     ADDRESS_TO_L2_READY_INS,
    input  logic [ADDRESS_WIDTH-3:0] ADDRESS_TO_L2_INS,
    output logic                     DATA_FROM_L2_VALID_INS,
    input  logic                     DATA_FROM_L2_READY_INS,
    output logic [L2_BUS_WIDTH-1:0]  DATA_FROM_L2_INS,
    output logic                     MEM_REQ_VALID,
    input  logic                     MEM_REQ_READY,
    output logic [ADDRESS_WIDTH-3:0] MEM_ADDR,
    input  logic                     MEM_RDATA_VALID,
    input  logic [L2_BUS_WIDTH-1:0]  MEM_RDATA,
    output logic                     BUSY
);

    localparam int BEATS    = WORD_PER_BLOCK * 32 / L2_BUS_WIDTH;
    localparam int WPB_BEAT = L2_BUS_WIDTH / 32;
    localparam int WAW      = ADDRESS_WIDTH - 2;       // word-address width
    localparam int OFF_W    = $clog2(WORD_PER_BLOCK);  // word offset within block
    localparam int SUB_W    = $clog2(WPB_BEAT);        // word offset within beat
    localparam int BEAT_W   = OFF_W - SUB_W;           // beat index within block
    localparam int BASE_W   = WAW - OFF_W;             // block number

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_SEND
    } state_e;

    state_e                    state_q,         state_d;
    logic [BASE_W-1:0]         base_q,          base_d;
    logic [BEAT_W-1:0]         beat_q,          beat_d;
    logic [BEAT_W-1:0]         count_q,         count_d;
    logic                      ready_q,         ready_d;
    logic                      data_valid_q,    data_valid_d;
    logic                      mem_req_valid_q, mem_req_valid_d;
    logic                      busy_q,          busy_d;
    logic [WAW-1:0]            mem_addr_q,      mem_addr_d;
    logic [L2_BUS_WIDTH-1:0]   data_q,          data_d;

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the
        // case statement leaves it unassigned, which would infer a latch.
        state_d    = state_q;
        base_d     = base_q;
        beat_d     = beat_q;
        count_d    = count_q;
        mem_addr_d = mem_addr_q;
        data_d     = data_q;

        unique case (state_q)
            S_IDLE: begin
                // ready_q is still low in the first cycle after reset release.
                if (ADDRESS_TO_L2_VALID_INS && ready_q) begin
                    base_d  = ADDRESS_TO_L2_INS[WAW-1:OFF_W];
                    beat_d  = ADDRESS_TO_L2_INS[OFF_W-1:SUB_W];
                    count_d = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (MEM_REQ_READY) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // Read data arriving in any other state is not ours and is dropped.
                if (MEM_RDATA_VALID) begin
                    data_d  = MEM_RDATA;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (DATA_FROM_L2_READY_INS) begin
                    count_d = count_q + BEAT_W'(1);
                    // BEATS is a power of two, so the natural wrap of the
                    // beat index keeps the walk inside the block.
                    beat_d  = beat_q + BEAT_W'(1);
                    state_d = (count_q == BEAT_W'(BEATS - 1)) ? S_IDLE : S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // The address is formed on entry to REQ and stays put while REQ waits,
        // so it is stable for the whole memory handshake.
        if (state_d == S_REQ) begin
            mem_addr_d = {base_d, beat_d, {SUB_W{1'b0}}};
        end

        ready_d         = (state_d == S_IDLE);
        data_valid_d    = (state_d == S_SEND);
        mem_req_valid_d = (state_d == S_REQ);
        busy_d          = (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q         <= S_IDLE;
            base_q          <= '0;
            beat_q          <= '0;
            count_q         <= '0;
            ready_q         <= 1'b0;
            data_valid_q    <= 1'b0;
            mem_req_valid_q <= 1'b0;
            busy_q          <= 1'b0;
            mem_addr_q      <= '0;
            data_q          <= '0;
        end else begin
            state_q         <= state_d;
            base_q          <= base_d;
            beat_q          <= beat_d;
            count_q         <= count_d;
            ready_q         <= ready_d;
            data_valid_q    <= data_valid_d;
            mem_req_valid_q <= mem_req_valid_d;
            busy_q          <= busy_d;
            mem_addr_q      <= mem_addr_d;
            data_q          <= data_d;
        end
    end

    assign ADDRESS_TO_L2_READY_INS = ready_q;
    assign DATA_FROM_L2_VALID_INS  = data_valid_q;
    assign DATA_FROM_L2_INS        = data_q;
    assign MEM_REQ_VALID           = mem_req_valid_q;
    assign MEM_ADDR                = mem_addr_q;
    assign BUSY                    = busy_q;

endmodule

// File: tb/tb_l2_instruction_responder.sv
// -----------------------------------------------------------------------------
// Bench for l2_instruction_responder: a memory model and an L1 sink drive the
// two handshake sides, a monitor records every memory request and refill beat,
// and each refill is compared against the expected wrapped beat order and the
// memory contents for those beat addresses.
// -----------------------------------------------------------------------------
module tb_l2_instruction_responder;

    localparam int AW    = 32;
    localparam int WPB   = 16;
    localparam int W     = WPB * 8;
    localparam int WAW   = AW - 2;
    localparam int BEATS = 4;

    typedef logic [BEATS-1:0][WAW-1:0] addr4_t;
    typedef struct {
        logic [WAW-1:0] addr;
        addr4_t         exp_maddr;
    } vec_t;

    logic           CLK = 1'b0;
    logic           RST_N = 1'b0;
    logic           ADDRESS_TO_L2_VALID_INS = 1'b0;
    logic           ADDRESS_TO_L2_READY_INS;
    logic [WAW-1:0] ADDRESS_TO_L2_INS = '0;
    logic           DATA_FROM_L2_VALID_INS;
    logic           DATA_FROM_L2_READY_INS = 1'b0;
    logic [W-1:0]   DATA_FROM_L2_INS;
    logic           MEM_REQ_VALID;
    logic           MEM_REQ_READY = 1'b0;
    logic [WAW-1:0] MEM_ADDR;
    logic           MEM_RDATA_VALID = 1'b0;
    logic [W-1:0]   MEM_RDATA = '0;
    logic           BUSY;

    l2_instruction_responder #(.ADDRESS_WIDTH(AW), .WORD_PER_BLOCK(WPB)) dut (
        .CLK                     (CLK),
        .RST_N                   (RST_N),
        .ADDRESS_TO_L2_VALID_INS (ADDRESS_TO_L2_VALID_INS),
        .ADDRESS_TO_L2_READY_INS (ADDRESS_TO_L2_READY_INS),
        .ADDRESS_TO_L2_INS       (ADDRESS_TO_L2_INS),
        .DATA_FROM_L2_VALID_INS  (DATA_FROM_L2_VALID_INS),
        .DATA_FROM_L2_READY_INS  (DATA_FROM_L2_READY_INS),
        .DATA_FROM_L2_INS        (DATA_FROM_L2_INS),
        .MEM_REQ_VALID           (MEM_REQ_VALID),
        .MEM_REQ_READY           (MEM_REQ_READY),
        .MEM_ADDR                (MEM_ADDR),
        .MEM_RDATA_VALID         (MEM_RDATA_VALID),
        .MEM_RDATA               (MEM_RDATA),
        .BUSY                    (BUSY)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    // Environment knobs, written only by the main test process.
    int mem_lat_max     = 1;
    bit mem_rand        = 1'b0;
    bit l1_rand         = 1'b0;
    int mem_stall_until = 0;
    int l1_stall_until  = 0;
    int spur_req        = 0;

    // Monitor results.
    logic [WAW-1:0] obs_maddr[$];
    logic [W-1:0]   obs_beat[$];
    int             beat_edges[$];
    int             acc_edges[$];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Backing-memory contents: a fixed scramble of the word address.
    function automatic logic [31:0] mem_word(input logic [WAW-1:0] m);
        return ({2'b00, m} * 32'h9E37_79B1) ^ 32'hC3A5_0F0F;
    endfunction

    function automatic logic [W-1:0] beat_data(input logic [WAW-1:0] m);
        logic [W-1:0] d;
        for (int w = 0; w < W / 32; w++) d[w*32 +: 32] = mem_word(m + WAW'(w));
        return d;
    endfunction

    // Reference beat order: block base plus the wrapped beat index times 4 words.
    function automatic addr4_t model_beats(input logic [WAW-1:0] a);
        addr4_t      r;
        int unsigned base = a - (a % WPB);
        int unsigned b0   = (a % WPB) / 4;
        for (int k = 0; k < BEATS; k++) r[k] = WAW'(base + ((b0 + k) % BEATS) * 4);
        return r;
    endfunction

    function automatic vec_t mkv(input logic [WAW-1:0] a, input logic [WAW-1:0] e0,
                                 input logic [WAW-1:0] e1, input logic [WAW-1:0] e2,
                                 input logic [WAW-1:0] e3);
        vec_t v;
        v.addr = a;
        v.exp_maddr[0] = e0;
        v.exp_maddr[1] = e1;
        v.exp_maddr[2] = e2;
        v.exp_maddr[3] = e3;
        return v;
    endfunction

    // Memory model: one outstanding read, random latency, optional stalls and
    // spurious read-data pulses.
    initial begin : mem_proc
        bit             pend;
        int             lat_left;
        int             spur_done;
        logic [WAW-1:0] pend_addr;
        logic           acc;
        logic [WAW-1:0] acc_a;
        pend = 1'b0; lat_left = 0; spur_done = 0; pend_addr = '0;
        forever begin
            @(negedge CLK);
            acc   = MEM_REQ_VALID && MEM_REQ_READY;
            acc_a = MEM_ADDR;
            @(posedge CLK);
            #1;
            MEM_RDATA_VALID = 1'b0;
            MEM_RDATA       = {$urandom, $urandom, $urandom, $urandom};
            if (!RST_N) begin
                pend = 1'b0;
            end else begin
                if (acc) begin
                    pend      = 1'b1;
                    pend_addr = acc_a;
                    lat_left  = int'($urandom_range(1, mem_lat_max));
                end
                if (pend) begin
                    lat_left--;
                    if (lat_left == 0) begin
                        MEM_RDATA_VALID = 1'b1;
                        MEM_RDATA       = beat_data(pend_addr);
                        pend            = 1'b0;
                    end
                end else if (spur_req != spur_done) begin
                    spur_done++;
                    MEM_RDATA_VALID = 1'b1;
                end
            end
            MEM_REQ_READY = (cyc >= mem_stall_until) && (!mem_rand || $urandom_range(0, 1) == 1);
        end
    end

    // L1 sink ready.
    initial begin : l1_proc
        forever begin
            @(posedge CLK);
            #1;
            DATA_FROM_L2_READY_INS = (cyc >= l1_stall_until) && (!l1_rand || $urandom_range(0, 1) == 1);
        end
    end

    // Monitor: records handshakes, checks hold-until-ready stability and latency.
    initial begin : monitor
        bit           mreq_hold, dat_hold, expect_mreq, expect_dvalid, outstanding;
        int           beats_in_refill;
        logic [WAW-1:0] hold_maddr;
        logic [W-1:0] hold_data, exp_cap;
        mreq_hold = 0; dat_hold = 0; expect_mreq = 0; expect_dvalid = 0; outstanding = 0;
        beats_in_refill = 0; hold_maddr = '0; hold_data = '0; exp_cap = '0;
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                mreq_hold = 0; dat_hold = 0; expect_mreq = 0; expect_dvalid = 0;
                outstanding = 0; beats_in_refill = 0;
                continue;
            end
            if (expect_mreq) check("mreq_latency", W'(MEM_REQ_VALID), W'(1));
            if (expect_dvalid) begin
                check("dvalid_latency", W'(DATA_FROM_L2_VALID_INS), W'(1));
                check("captured_data", DATA_FROM_L2_INS, exp_cap);
            end
            if (mreq_hold) begin
                check("mreq_held", W'(MEM_REQ_VALID), W'(1));
                check("maddr_stable", W'(MEM_ADDR), W'(hold_maddr));
            end
            if (dat_hold) begin
                check("dvalid_held", W'(DATA_FROM_L2_VALID_INS), W'(1));
                check("data_stable", DATA_FROM_L2_INS, hold_data);
            end
            expect_mreq   = 0;
            expect_dvalid = 0;
            if (ADDRESS_TO_L2_VALID_INS && ADDRESS_TO_L2_READY_INS) begin
                acc_edges.push_back(cyc + 1);
                expect_mreq = 1;
            end
            if (MEM_REQ_VALID && MEM_REQ_READY) begin
                obs_maddr.push_back(MEM_ADDR);
                outstanding = 1;
            end
            if (MEM_RDATA_VALID && outstanding) begin
                expect_dvalid = 1;
                exp_cap       = MEM_RDATA;
                outstanding   = 0;
            end
            if (DATA_FROM_L2_VALID_INS && DATA_FROM_L2_READY_INS) begin
                obs_beat.push_back(DATA_FROM_L2_INS);
                beat_edges.push_back(cyc + 1);
                beats_in_refill++;
                if (beats_in_refill < BEATS) expect_mreq = 1;
                else beats_in_refill = 0;
            end
            mreq_hold  = MEM_REQ_VALID && !MEM_REQ_READY;
            hold_maddr = MEM_ADDR;
            dat_hold   = DATA_FROM_L2_VALID_INS && !DATA_FROM_L2_READY_INS;
            hold_data  = DATA_FROM_L2_INS;
        end
    end

    // Present a miss address and hold it until the responder takes it.
    task automatic request(input logic [WAW-1:0] a);
        bit ok = 1'b0;
        ADDRESS_TO_L2_INS       = a;
        ADDRESS_TO_L2_VALID_INS = 1'b1;
        for (int t = 0; t < 300 && !ok; t++) begin
            @(negedge CLK);
            if (ADDRESS_TO_L2_READY_INS) ok = 1'b1;
        end
        @(posedge CLK);
        #1;
        ADDRESS_TO_L2_VALID_INS = 1'b0;
        check("request_accepted", W'(ok), W'(1));
    endtask

    task automatic wait_beats(input int n, input string tag);
        int t = 0;
        while (obs_beat.size() < n && t < 400) begin
            @(posedge CLK);
            #2;
            t++;
        end
        check({tag, " beat_count"}, W'(obs_beat.size() >= n), W'(1));
    endtask

    // Compare one refill's memory addresses and returned beats, in order.
    task automatic verify(input string tag, input addr4_t e);
        logic [WAW-1:0] ma;
        logic [W-1:0]   bd;
        for (int k = 0; k < BEATS; k++) begin
            ma = '1;
            bd = 'x;
            if (obs_maddr.size() != 0) ma = obs_maddr.pop_front();
            if (obs_beat.size() != 0) bd = obs_beat.pop_front();
            check($sformatf("%s maddr%0d", tag, k), W'(ma), W'(e[k]));
            check($sformatf("%s data%0d", tag, k), bd, beat_data(e[k]));
        end
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : main
        vec_t           vecs[5];
        logic [W-1:0]   prev;
        logic [WAW-1:0] a;
        bit             seen, stray;
        int             last_beat;

        vecs[0] = mkv(30'h0000_0100, 30'h0000_0100, 30'h0000_0104, 30'h0000_0108, 30'h0000_010C);
        vecs[1] = mkv(30'h0000_010B, 30'h0000_0108, 30'h0000_010C, 30'h0000_0100, 30'h0000_0104);
        vecs[2] = mkv(30'h0000_03FF, 30'h0000_03FC, 30'h0000_03F0, 30'h0000_03F4, 30'h0000_03F8);
        vecs[3] = mkv(30'h3FFF_FFF5, 30'h3FFF_FFF4, 30'h3FFF_FFF8, 30'h3FFF_FFFC, 30'h3FFF_FFF0);
        vecs[4] = mkv(30'h0000_0006, 30'h0000_0004, 30'h0000_0008, 30'h0000_000C, 30'h0000_0000);

        // Reset values.
        #12;
        check("rst ready", W'(ADDRESS_TO_L2_READY_INS), W'(0));
        check("rst dvalid", W'(DATA_FROM_L2_VALID_INS), W'(0));
        check("rst data", DATA_FROM_L2_INS, W'(0));
        check("rst mreq", W'(MEM_REQ_VALID), W'(0));
        check("rst maddr", W'(MEM_ADDR), W'(0));
        check("rst busy", W'(BUSY), W'(0));
        #1 RST_N = 1'b1;
        @(posedge CLK);
        #1;
        check("post-rst ready", W'(ADDRESS_TO_L2_READY_INS), W'(1));
        check("post-rst busy", W'(BUSY), W'(0));

        // Table vectors: latency 1, L1 always ready.
        foreach (vecs[i]) begin
            request(vecs[i].addr);
            check($sformatf("vec%0d busy", i), W'(BUSY), W'(1));
            check($sformatf("vec%0d ready_low", i), W'(ADDRESS_TO_L2_READY_INS), W'(0));
            wait_beats(BEATS, $sformatf("vec%0d", i));
            verify($sformatf("vec%0d", i), vecs[i].exp_maddr);
        end

        // Backpressure: memory stalls the first request, L1 stalls beat 1.
        mem_stall_until = cyc + 4;
        request(30'h0000_0200);
        wait_beats(1, "bp first");
        l1_stall_until = cyc + 8;
        wait_beats(BEATS, "bp");
        verify("bp", model_beats(30'h0000_0200));

        // Busy stall: second request waits for the cycle after the last beat.
        beat_edges.delete();
        acc_edges.delete();
        request(30'h0000_0523);
        request(30'h0000_0A3C);
        wait_beats(2 * BEATS, "stall");
        last_beat = (beat_edges.size() >= BEATS) ? beat_edges[BEATS-1] : -1;
        check("stall accept_edge", W'(acc_edges.size() >= 2 ? acc_edges[1] : -1), W'(last_beat + 1));
        verify("stall A", model_beats(30'h0000_0523));
        verify("stall B", model_beats(30'h0000_0A3C));

        // Spurious read data while idle.
        prev = DATA_FROM_L2_INS;
        spur_req++;
        repeat (3) @(posedge CLK);
        #2;
        check("spur idle dvalid", W'(DATA_FROM_L2_VALID_INS), W'(0));
        check("spur idle data", DATA_FROM_L2_INS, prev);
        check("spur idle busy", W'(BUSY), W'(0));
        check("spur idle ready", W'(ADDRESS_TO_L2_READY_INS), W'(1));

        // Spurious read data while the memory request is stalled.
        mem_stall_until = cyc + 8;
        request(30'h0000_0047);
        prev = DATA_FROM_L2_INS;
        spur_req++;
        repeat (3) @(posedge CLK);
        #2;
        check("spur req mreq", W'(MEM_REQ_VALID), W'(1));
        check("spur req dvalid", W'(DATA_FROM_L2_VALID_INS), W'(0));
        check("spur req data", DATA_FROM_L2_INS, prev);
        wait_beats(BEATS, "spur");
        verify("spur", model_beats(30'h0000_0047));

        // Randomized refills with random latency and handshake stalls.
        mem_lat_max = 5;
        mem_rand    = 1'b1;
        l1_rand     = 1'b1;
        for (int i = 0; i < 30; i++) begin
            a = WAW'($urandom);
            request(a);
            wait_beats(BEATS, $sformatf("rnd%0d", i));
            verify($sformatf("rnd%0d a=%h", i, a), model_beats(a));
        end
        mem_rand    = 1'b0;
        l1_rand     = 1'b0;
        mem_lat_max = 1;

        // Reset in the middle of a refill, while a beat is being presented.
        l1_stall_until = cyc + 100000;
        request(30'h0000_0300);
        seen = 1'b0;
        for (int t = 0; t < 100 && !seen; t++) begin
            @(negedge CLK);
            if (DATA_FROM_L2_VALID_INS) seen = 1'b1;
        end
        check("midrst reached_send", W'(seen), W'(1));
        @(posedge CLK);
        #3;
        RST_N = 1'b0;
        #1;
        check("midrst dvalid", W'(DATA_FROM_L2_VALID_INS), W'(0));
        check("midrst data", DATA_FROM_L2_INS, W'(0));
        check("midrst mreq", W'(MEM_REQ_VALID), W'(0));
        check("midrst maddr", W'(MEM_ADDR), W'(0));
        check("midrst busy", W'(BUSY), W'(0));
        check("midrst ready", W'(ADDRESS_TO_L2_READY_INS), W'(0));
        l1_stall_until = 0;
        repeat (2) @(posedge CLK);
        #3;
        obs_maddr.delete();
        obs_beat.delete();
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        check("midrst ready_after", W'(ADDRESS_TO_L2_READY_INS), W'(1));
        stray = 1'b0;
        repeat (10) begin
            @(negedge CLK);
            if (DATA_FROM_L2_VALID_INS || MEM_REQ_VALID || BUSY) stray = 1'b1;
        end
        check("midrst no_stray", W'(stray), W'(0));
        check("midrst no_beats", W'(obs_beat.size()), W'(0));

        // Recovery refill after the abandoned one.
        request(30'h0000_0ABC);
        wait_beats(BEATS, "recover");
        verify("recover", model_beats(30'h0000_0ABC));

        repeat (3) @(posedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
